// File: rtl/svm_pkg.sv
// svm_pkg: shared sizing helpers and the FSM state type for the one-vs-one
// SVM classifier.
//   pairs_f(classes)     number of one-vs-one pairs
//   depth_f(classes,d)   coefficient words (weights + bias per pair)
//   acc_w_f(w,d)         accumulator width that cannot overflow
//   state_t              controller state encoding
package svm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_VOTE,
    ST_ARGMAX,
    ST_DONE
  } state_t;

  function automatic int pairs_f(input int classes);
    return classes * (classes - 1) / 2;
  endfunction

  function automatic int depth_f(input int classes, input int dims);
    return pairs_f(classes) * (dims + 1);
  endfunction

  // DIMS products of 2W bits plus one bias word.
  function automatic int acc_w_f(input int w, input int dims);
    return 2 * w + $clog2(dims + 1);
  endfunction

endpackage

// File: rtl/svm_mac.sv
// svm_mac: signed multiply-accumulate for one pair's decision value.
//   clk_i, rst_i  clock, synchronous active-high reset (clears acc_o)
//   en_i          accumulate this cycle
//   load_i        with en_i: start from the sign-extended bias instead of acc_o
//   a_i, b_i      signed feature and weight
//   bias_i        signed bias of the current pair
//   acc_o         signed accumulator
module svm_mac
  import svm_pkg::*;
#(
  parameter int W    = 16,
  parameter int ACCW = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   load_i,
  input  logic signed [W-1:0]    a_i,
  input  logic signed [W-1:0]    b_i,
  input  logic signed [W-1:0]    bias_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [2*W-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic signed [ACCW-1:0] base;

  assign prod     = a_i * b_i;
  assign prod_ext = {{(ACCW-2*W){prod[2*W-1]}}, prod};
  assign bias_ext = {{(ACCW-W){bias_i[W-1]}}, bias_i};
  // The first product of a pair is folded in together with the bias, so the
  // bias load costs no extra cycle.
  assign base     = load_i ? bias_ext : acc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_o <= '0;
    end else if (en_i) begin
      acc_o <= base + prod_ext;
    end
  end

endmodule

// File: rtl/svm_ovo_seq.sv
// svm_ovo_seq: sequential one-vs-one linear SVM classifier. One MAC per
// cycle per pair, one vote per pair, then a sequential argmax over the votes.
//   clk_i, rst_i              clock, synchronous active-high reset
//   cfg_we_i/addr_i/data_i    coefficient write port (address p*(DIMS+1)+k)
//   cfg_drop_o                pulses the cycle after a discarded write
//   in_valid_i/in_ready_o     sample handshake, in_data_i packed dim 0 in LSBs
//   out_valid_o/out_ready_i   result handshake
//   class_o                   winning class, held until the next result
//   votes_o                   per-class vote tallies, class 0 in LSBs
//                             (only when SVM_VOTES_EN is defined)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a sample, coefficient writes allowed
// ST_MAC    | accumulating one dimension per cycle for the current pair
// ST_VOTE   | cast the vote of the current pair, step to the next pair
// ST_ARGMAX | scan vote tallies from class 0 upwards
// ST_DONE   | result presented until out_ready_i
module svm_ovo_seq
  import svm_pkg::*;
#(
  parameter int W       = 16,
  parameter int DIMS    = 21,
  parameter int CLASSES = 3,
  localparam int PAIRS  = pairs_f(CLASSES),
  localparam int DEPTH  = depth_f(CLASSES, DIMS),
  localparam int AW     = $clog2(DEPTH),
  localparam int CLW    = $clog2(CLASSES)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  logic [AW-1:0]       cfg_addr_i,
  input  logic [W-1:0]        cfg_data_i,
  output logic                cfg_drop_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DIMS*W-1:0]   in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CLW-1:0]      class_o
`ifdef SVM_VOTES_EN
  ,
  output logic [CLASSES*CLW-1:0] votes_o
`endif
);

  localparam int ACCW = acc_w_f(W, DIMS);
  localparam int CW   = $clog2(DIMS + CLASSES + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t                      state;
  logic signed [W-1:0]         coef_mem [DEPTH];
  logic [DIMS*W-1:0]           x_sh;
  logic [AW-1:0]               waddr;
  logic [CW-1:0]               cnt;
  logic [CLW-1:0]              pi, pj;
  logic [CLASSES-1:0][CLW-1:0] votes;
  logic [CLW-1:0]              sidx, best_idx, best_v;

  logic                        cfg_ok;
  logic                        mac_en, mac_load;
  logic signed [W-1:0]         mac_a, mac_w, mac_bias;
  logic signed [ACCW-1:0]      acc;
  logic                        acc_pos, last_pair, take;

  assign cfg_ok = (state == ST_IDLE) && ({1'b0, cfg_addr_i} < DEPTH_C);

  // Coefficient store: no reset, so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && cfg_ok && !rst_i) begin
      coef_mem[cfg_addr_i] <= cfg_data_i;
    end
  end

  // waddr walks the weights of the current pair; on the first MAC cycle it
  // points at the pair base, so the bias sits DIMS words further on.
  assign mac_en   = (state == ST_MAC);
  assign mac_load = (cnt == CW'(DIMS - 1));
  assign mac_a    = $signed(x_sh[W-1:0]);
  assign mac_w    = coef_mem[waddr];
  assign mac_bias = coef_mem[waddr + AW'(DIMS)];

  svm_mac #(
    .W    (W),
    .ACCW (ACCW)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (mac_en),
    .load_i (mac_load),
    .a_i    (mac_a),
    .b_i    (mac_w),
    .bias_i (mac_bias),
    .acc_o  (acc)
  );

  assign acc_pos   = !acc[ACCW-1] && (acc != '0);
  assign last_pair = (pi == CLW'(CLASSES - 2)) && (pj == CLW'(CLASSES - 1));
  assign take      = (sidx == '0) || (votes[sidx] > best_v);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      class_o     <= '0;
      cfg_drop_o  <= 1'b0;
      votes       <= '0;
      x_sh        <= '0;
      waddr       <= '0;
      cnt         <= '0;
      pi          <= '0;
      pj          <= CLW'(1);
      sidx        <= '0;
      best_idx    <= '0;
      best_v      <= '0;
    end else begin
      cfg_drop_o <= cfg_we_i && !cfg_ok;
      unique case (state)
        ST_IDLE: begin
          if (in_valid_i) begin
            x_sh       <= in_data_i;
            votes      <= '0;
            pi         <= '0;
            pj         <= CLW'(1);
            waddr      <= '0;
            cnt        <= CW'(DIMS - 1);
            in_ready_o <= 1'b0;
            state      <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Rotate rather than shift: every pair reuses the same sample.
          x_sh  <= {x_sh[W-1:0], x_sh[DIMS*W-1:W]};
          waddr <= waddr + 1'b1;
          if (cnt == '0) begin
            state <= ST_VOTE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_VOTE: begin
          if (acc_pos) begin
            votes[pi] <= votes[pi] + 1'b1;
          end else begin
            votes[pj] <= votes[pj] + 1'b1;
          end
          waddr <= waddr + 1'b1;  // step over the bias word
          if (last_pair) begin
            cnt   <= CW'(CLASSES - 1);
            sidx  <= '0;
            state <= ST_ARGMAX;
          end else begin
            if (pj == CLW'(CLASSES - 1)) begin
              pi <= pi + 1'b1;
              pj <= pi + CLW'(2);
            end else begin
              pj <= pj + 1'b1;
            end
            cnt   <= CW'(DIMS - 1);
            state <= ST_MAC;
          end
        end
        ST_ARGMAX: begin
          if (take) begin
            best_idx <= sidx;
            best_v   <= votes[sidx];
          end
          sidx <= sidx + 1'b1;
          if (cnt == '0) begin
            class_o     <= take ? sidx : best_idx;
            out_valid_o <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SVM_VOTES_EN
  assign votes_o = votes;
`else
  // Tallies stay internal when the vote port is not built.
`endif

endmodule

// File: tb/tb_svm_ovo_seq.sv
module tb_svm_ovo_seq;

  localparam int W       = 16;
  localparam int DIMS    = 21;
  localparam int CLASSES = 3;
  localparam int DEPTH   = 66;
  localparam int LAT     = 69;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_we = 1'b0;
  logic [6:0]          cfg_addr = '0;
  logic [W-1:0]        cfg_data = '0;
  logic                cfg_drop_o;
  logic                in_valid = 1'b0;
  logic                in_ready_o;
  logic [DIMS*W-1:0]   in_data = '0;
  logic                out_valid_o;
  logic                out_ready = 1'b0;
  logic [1:0]          class_o;
`ifdef SVM_VOTES_EN
  logic [5:0]          votes_o;
`endif

  svm_ovo_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .cfg_drop_o  (cfg_drop_o),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .class_o     (class_o)
`ifdef SVM_VOTES_EN
    ,
    .votes_o     (votes_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mirror [DEPTH];
  bit     m_busy = 1'b0;
  bit     m_valid = 1'b0;
  bit     m_drop = 1'b0;
  int     m_cnt = 0;
  int     m_cls = 0;
  int     m_pend_cls = 0;
  logic [5:0] m_votes = '0;
  logic [5:0] m_pend_votes = '0;
  longint m_acc0 = 0;

  // Decision values are plain integer dot products; pairs in (i,j) order.
  function automatic void model_eval(input logic [DIMS*W-1:0] x, output int cls,
                                     output logic [5:0] vts, output longint acc0);
    int v [CLASSES];
    int p;
    longint acc;
    p = 0;
    acc0 = 0;
    for (int k = 0; k < CLASSES; k++) v[k] = 0;
    for (int i = 0; i < CLASSES; i++) begin
      for (int j = i + 1; j < CLASSES; j++) begin
        acc = longint'($signed(mirror[p*(DIMS+1)+DIMS]));
        for (int d = 0; d < DIMS; d++)
          acc += longint'($signed(x[d*W +: W])) * longint'($signed(mirror[p*(DIMS+1)+d]));
        if (p == 0) acc0 = acc;
        if (acc > 0) v[i]++; else v[j]++;
        p++;
      end
    end
    cls = 0;
    for (int k = 1; k < CLASSES; k++) if (v[k] > v[cls]) cls = k;
    for (int k = 0; k < CLASSES; k++) vts[2*k +: 2] = 2'(v[k]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_drop = 0; m_cnt = 0; m_cls = 0; m_votes = '0;
    end else begin
      m_drop = cfg_we && !(!m_busy && cfg_addr < DEPTH);
      if (!m_busy && cfg_we && cfg_addr < DEPTH) mirror[cfg_addr] = cfg_data;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_cnt = 0;
          model_eval(in_data, m_pend_cls, m_pend_votes, m_acc0);
        end
      end else if (!m_valid) begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_valid = 1; m_cls = m_pend_cls; m_votes = m_pend_votes;
        end
      end else if (out_ready) begin
        m_valid = 0; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready_o, !m_busy);
      chk("out_valid", out_valid_o, m_valid);
      chk("class", class_o, m_cls);
      chk("cfg_drop", cfg_drop_o, m_drop);
`ifdef SVM_VOTES_EN
      if (m_valid) chk("votes", votes_o, m_votes);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_wr(input int a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = 7'(a); cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_coeffs(input logic [W-1:0] wv, input logic [W-1:0] b0,
                             input logic [W-1:0] b1, input logic [W-1:0] b2);
    for (int a = 0; a < DEPTH; a++) begin
      if (a % 22 != 21) cfg_wr(a, wv);
      else if (a / 22 == 0) cfg_wr(a, b0);
      else if (a / 22 == 1) cfg_wr(a, b1);
      else cfg_wr(a, b2);
    end
  endtask

  task automatic run_sample(input logic [DIMS*W-1:0] x, input int exp_cls, input int hold,
                            input bit wr, input int wa, input logic [W-1:0] wd);
    int n;
    in_valid = 1'b1; in_data = x;
    if (wr) begin cfg_we = 1'b1; cfg_addr = 7'(wa); cfg_data = wd; end
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (!out_valid_o && n < 200) begin tick(); n++; end
    chk("latency", n, LAT);
    chk("class_lit", class_o, exp_cls);
    if (hold > 0) begin
      in_valid = 1'b1; in_data = ~x;
      for (int c = 0; c < hold; c++) tick();
      in_valid = 1'b0;
      chk("class_hold", class_o, exp_cls);
      chk("ready_hold", in_ready_o, 0);
      chk("valid_hold", out_valid_o, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ready_after", in_ready_o, 1);
  endtask

  logic [DIMS*W-1:0] xs;

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", in_ready_o, 1);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_class", class_o, 0);

    xs = '0;
    for (int d = 0; d < DIMS; d++) xs[d*W +: W] = 16'(d * 37 - 300);

    // weights 0, biases +1: votes {2,1,0}; also hold DONE for 10 cycles
    load_coeffs(16'h0000, 16'h0001, 16'h0001, 16'h0001);
    run_sample(xs, 0, 10, 1'b0, 0, 16'h0);
    // biases -1: votes {0,1,2}
    load_coeffs(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_sample(xs, 2, 0, 1'b0, 0, 16'h0);
    // biases +1,-1,+1: votes {1,1,1}, tie to lowest
    load_coeffs(16'h0000, 16'h0001, 16'hFFFF, 16'h0001);
    run_sample(xs, 0, 0, 1'b0, 0, 16'h0);

    // write during MAC is dropped, then reset mid-MAC
    in_valid = 1'b1; in_data = xs;
    tick();
    in_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = 7'd21; cfg_data = 16'hFFFF;
    tick();
    cfg_we = 1'b0;
    chk("drop_busy", cfg_drop_o, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", in_ready_o, 1);
    chk("midrst_valid", out_valid_o, 0);
    cfg_wr(66, 16'h1234);
    chk("drop_range", cfg_drop_o, 1);
    // bias of pair 0 must still be +1, otherwise class 1 would win
    run_sample(xs, 0, 0, 1'b0, 0, 16'h0);

    // extreme product: 0x7FFF * 0x8000 on pair 0 -> class 1 vote; votes {0,1,2}
    load_coeffs(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    cfg_wr(0, 16'h8000);
    xs = '0;
    xs[15:0] = 16'h7FFF;
    run_sample(xs, 2, 0, 1'b0, 0, 16'h0);
    chk("model_acc0", m_acc0, -64'sd1073709056);
    chk("model_class", m_pend_cls, 2);

    // write and accept together: new weight +1 gives votes {2,1,0},
    // the stale 0x8000 would give {1,2,0}
    cfg_wr(43, 16'h0001);
    cfg_wr(65, 16'h0001);
    run_sample(xs, 0, 0, 1'b1, 0, 16'h0001);
    chk("model_class2", m_pend_cls, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
